// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - request/trap/acknowledge bundle between peripherals, CSR file and interrupt_controller
interface interrupt_controller_if #(
    parameter int N_IRQ = 16
);
    logic [N_IRQ-1:0] irq_req_i;
    logic [31:0]      mie_i;
    logic             core_stall_i;
    logic             int_rst_i;
    logic             int_o;
    logic [31:0]      mcause_o;
    logic [N_IRQ-1:0] irq_ret_o;
    logic             busy_o;

    modport slave (
        input  irq_req_i,
        input  mie_i,
        input  core_stall_i,
        input  int_rst_i,
        output int_o,
        output mcause_o,
        output irq_ret_o,
        output busy_o
    );

    modport master (
        output irq_req_i,
        output mie_i,
        output core_stall_i,
        output int_rst_i,
        input  int_o,
        input  mcause_o,
        input  irq_ret_o,
        input  busy_o
    );
endinterface

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - machine-level interrupt arbiter raising one-shot traps; INTC_ROUND_ROBIN_EN selects round-robin over fixed priority
module interrupt_controller #(
    parameter int N_IRQ = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    interrupt_controller_if.slave  bus
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        SERVICE = 2'd2,
        ACK     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    sel;
    logic [31:0]      mcause_q, mcause_d;
    logic [N_IRQ-1:0] pending;
    logic             unused_mie;

    assign pending    = bus.irq_req_i & bus.mie_i[16 +: N_IRQ];
    assign unused_mie = ^bus.mie_i;

`ifdef INTC_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Scan starts at ptr and wraps; the first pending line found wins.
    always_comb begin
        int   j;
        logic found;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_IRQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_IRQ) begin
                j = j - N_IRQ;
            end
            if (!found && pending[IW'(j)]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mcause_d = mcause_q;
`ifdef INTC_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    idx_d    = sel;
                    mcause_d = 32'h8000_0010 | 32'(sel);
                    state_d  = TRAP;
`ifdef INTC_ROUND_ROBIN_EN
                    ptr_d    = (int'(sel) == N_IRQ - 1) ? '0 : sel + IW'(1);
`endif
                end
            end
            TRAP: begin
                if (!bus.core_stall_i) begin
                    state_d = SERVICE;
                end
            end
            // Requests and mie are deliberately ignored until the ACK completes.
            SERVICE: begin
                if (bus.int_rst_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mcause_q <= mcause_d;
        end
    end

`ifdef INTC_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.int_o     = (state_q == TRAP);
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.mcause_o  = mcause_q;
    assign bus.irq_ret_o = (state_q == ACK) ? (N_IRQ'(1) << idx_q) : '0;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Machine-level interrupt controller upstream of the CSR file. Arbitrates up to `N_IRQ` peripheral requests against the CSR `mie` mask and raises a one-shot trap request to the core. The core uses the trap request to drive the CSR trap operation (save PC to `mepc`, load `mcause`) and redirect fetch to `mtvec`. On `mret` the block acknowledges the serviced peripheral and re-arms; nesting is not supported.

## Interface
- `N_IRQ`, 16, number of interrupt lines (1..16); line `i` maps to `mcause` code `16+i`.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `irq_req_i`  in  N_IRQ  level-sensitive requests; held high until acknowledged.
- `mie_i`  in  32  CSR `mie` value; bit `16+i` enables line `i`.
- `core_stall_i`  in  1  core cannot accept a trap this cycle.
- `int_rst_i`  in  1  single-cycle pulse, `mret` retired.
- `int_o`  out  1  trap request to core/CSR (CSR trap-op bit).
- `mcause_o`  out  32  cause for CSR `mcause` write.
- `irq_ret_o`  out  N_IRQ  one-hot, one-cycle acknowledge to the serviced peripheral.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- `pending = irq_req_i & mie_i[16+N_IRQ-1:16]`, combinational.
- IDLE, when `pending != 0`:
  - select index `sel`;
  - register `idx <= sel` and `mcause_o <= 32'h8000_0000 | (16+sel)`;
  - go to TRAP.
- IDLE, when `pending == 0`: stay in IDLE.
- TRAP:
  - `int_o = 1`;
  - if `core_stall_i = 1`, stay in TRAP and hold `int_o` and `mcause_o`;
  - otherwise go to SERVICE.
  - `int_o` is therefore high for exactly one unstalled cycle.
- SERVICE:
  - hold `mcause_o`;
  - new or changed requests and `mie_i` changes have no effect;
  - on `int_rst_i = 1`, go to ACK.
- ACK:
  - `irq_ret_o = 1 << idx` for one cycle;
  - go to IDLE.
- Once latched, a request that drops during TRAP or SERVICE is still completed.
- `int_rst_i` outside SERVICE is ignored.
- `int_rst_i` together with a new request is not a conflict: requests are only evaluated in IDLE.
- `irq_ret_o` is zero outside ACK.
- `int_o` is zero outside TRAP.
- `mcause_o` keeps its last value in IDLE.
- `busy_o = (state != IDLE)`.
- Reset values: state IDLE, `idx = 0`, `mcause_o = 0`, round-robin pointer `0`, `int_o = 0`, `irq_ret_o = 0`, `busy_o = 0`.
- Reset mid-operation drops the in-flight interrupt with no acknowledge. The peripheral keeps its request, so it is re-serviced after reset if enabled.

## Timing
- `int_o`, `irq_ret_o` and `busy_o` are decoded from registered state only; no combinational path from inputs.
- Request latency: pending at edge k in IDLE; `int_o` high in cycle k+1; `mcause_o` valid in the same cycle.
- Return latency: `int_rst_i` at edge m in SERVICE; `irq_ret_o` in cycle m+1; IDLE at m+2.
- The earliest next trap is `int_o` at m+3, given a still-pending line at edge m+2. The peripheral must drop its request within the ACK cycle.
- Minimum loop with no stall is 4 cycles: IDLE, TRAP, SERVICE, ACK.

## Configuration
- `INTC_ROUND_ROBIN_EN` undefined:
  - fixed priority; lowest pending index wins;
  - the round-robin pointer is not implemented.
- `INTC_ROUND_ROBIN_EN` defined:
  - the search starts at `ptr`, wraps modulo `N_IRQ`, and the first pending index wins;
  - on leaving IDLE, `ptr <= (sel+1) mod N_IRQ`;
  - `ptr` resets to 0.

## Test plan
- Reset, then `irq_req_i[3]=1`, `mie_i=32'h0008_0000`:
  - `int_o` goes high 1 cycle later for 1 cycle;
  - `mcause_o=32'h8000_0013`;
  - after an `int_rst_i` pulse, `irq_ret_o=16'h0008` for 1 cycle.
- `irq_req_i[5]=1` with `mie_i=0`: `int_o` never asserts and `busy_o` stays 0. Then set `mie_i[21]=1`: trap with `mcause_o=32'h8000_0015`.
- `core_stall_i=1` for 3 cycles during TRAP: `int_o` is held for 4 cycles and `mcause_o` is stable.
- Lines 2 and 7 held pending and acknowledged repeatedly:
  - without the macro, line 2 is always served;
  - with `INTC_ROUND_ROBIN_EN`, service alternates 2, 7, 2.
- In SERVICE: drop the request, pulse `int_rst_i` twice, and assert a new line 1. Required: exactly one `irq_ret_o` for the original line; the line-1 trap follows from IDLE.
- Assert `rst_ni` low mid-SERVICE: all outputs are 0 immediately (asynchronous). After release, the still-pending line traps again.
